// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: 1 start, 9 data (LSB first), 1 stop, with a one-deep holding register.
// Define DEBUG_TX_PARITY_EN to send even parity of [7:0] as bit 8 instead of tx_frame[8].
module debug_uart_tx #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       debug,
  input  logic       tx_valid,
  input  logic [8:0] tx_frame,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [8:0]    shifter, shifter_n;
  logic [8:0]    hold;
  logic          hold_full;
  logic [8:0]    frame_in;
  logic          accept, bit_end, stop_end;
  logic          tx_d, done_d;

`ifdef DEBUG_TX_PARITY_EN
  assign frame_in = {^tx_frame[7:0], tx_frame[7:0]};
`else
  assign frame_in = tx_frame;
`endif

  assign tx_ready = debug & ~hold_full;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (baud_cnt == BAUD_MAX);
  assign stop_end = (state == STOP) & bit_end;
  assign tx_busy  = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and shifter/counter next values
  always_comb begin
    state_n    = state;
    shifter_n  = shifter;
    bit_idx_n  = bit_idx;
    baud_cnt_n = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: if (accept) begin
        state_n   = START;
        shifter_n = frame_in;
      end
      START: if (bit_end) begin
        state_n   = DATA;
        bit_idx_n = 4'd0;
      end
      DATA: if (bit_end) begin
        if (bit_idx == 4'd8) state_n = STOP;
        else begin
          bit_idx_n = bit_idx + 4'd1;
          shifter_n = shifter >> 1;
        end
      end
      STOP: if (bit_end) begin
        // A queued frame (or one accepted this very cycle) starts with no idle gap.
        if (hold_full && debug) begin
          state_n   = START;
          shifter_n = hold;
        end else if (accept) begin
          state_n   = START;
          shifter_n = frame_in;
        end else begin
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode: tx is registered from the next state so it lines up with the bit period.
  always_comb begin
    tx_d   = 1'b1;
    done_d = stop_end;
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifter_n[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shifter  <= shifter_n;
      tx       <= tx_d;
      tx_done  <= done_d;
    end
  end

  // Holding register: filled only while the shifter is busy, drained at stop end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (!debug) begin
      hold_full <= 1'b0;
    end else if (stop_end) begin
      hold_full <= 1'b0;
    end else if (accept && state != IDLE) begin
      hold      <= frame_in;
      hold_full <= 1'b1;
    end
  end

endmodule
